// File: rtl/arithmetic_fu_pipe.sv
// Pipelined ADD/SUB/SLT/SLTU/MIN/MAX unit with ROB tag; latency STAGES cycles, 1 op/cycle.
// Valid/ready backpressure from the CDB side fills the pipe up to STAGES ops; flush drops all in-flight ops.
module arithmetic_fu_pipe #(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic             additional_info,
  input  logic [2:0]       arithmetic_type,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);

  typedef struct packed {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [STAGES-1:0] valid_q;
  entry_t            stage_q [STAGES];
  logic [STAGES-1:0] load;
  logic              go;
  logic              lt_s;
  logic              lt_u;
  logic [XLEN-1:0]   alu_res;

  assign lt_s = $signed(rs1) < $signed(rs2);
  assign lt_u = rs1 < rs2;

  always_comb begin
    alu_res = '0;
    case (arithmetic_type)
      3'd0: alu_res = additional_info ? (rs1 - rs2) : (rs1 + rs2);
      3'd2: alu_res = {{(XLEN-1){1'b0}}, lt_s};
      3'd3: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      // additional_info flips MIN into MAX by inverting which operand wins
      3'd4: alu_res = (lt_s ^ additional_info) ? rs1 : rs2;
      3'd5: alu_res = (lt_u ^ additional_info) ? rs1 : rs2;
      default: alu_res = '0;
    endcase
  end

  // A stage may load when it is empty or its content moves on; the chain runs back from the CDB.
  always_comb begin
    load = '0;
    go   = ready_out;
    for (int i = STAGES - 1; i >= 0; i--) begin
      load[i] = !valid_q[i] | go;
      go      = load[i];
    end
  end

  assign ready_in = load[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      if (load[0]) begin
        valid_q[0] <= valid_in;
        if (valid_in) begin
          stage_q[0] <= '{res: alu_res, tag: tag_in};
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load[i]) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end
      if (flush) begin
        valid_q <= '0;
      end
    end
  end

  assign valid_out = valid_q[STAGES-1];
  assign result    = stage_q[STAGES-1].res;
  assign tag_out   = stage_q[STAGES-1].tag;

endmodule
